// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multicycle control FSM for a small MIPS subset.
// It produces the PC, IR, register file and data memory enables and counts retired instructions.
module pc_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  NPCOp,
  output logic        RegWr,
  output logic        DMWr,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t cur, nxt;
  logic pc_wr, ir_wr, reg_wr, dm_wr, retire;
  logic [1:0] npc_op;
  logic rtype, addu, subu, jr, ori, lui, lw, sw, beq, j, jal, alu, legal;
  assign rtype = op == 6'b000000;
  assign addu  = rtype && funct == 6'b100001;
  assign subu  = rtype && funct == 6'b100011;
  assign jr    = rtype && funct == 6'b001000;
  assign ori   = op == 6'b001101;
  assign lui   = op == 6'b001111;
  assign lw    = op == 6'b100011;
  assign sw    = op == 6'b101011;
  assign beq   = op == 6'b000100;
  assign j     = op == 6'b000010;
  assign jal   = op == 6'b000011;
  assign alu   = addu | subu | ori | lui;
  assign legal = alu | lw | sw | beq | j | jal | jr;
  always_comb begin
    nxt    = FETCH;
    pc_wr  = 1'b0;
    ir_wr  = 1'b0;
    npc_op = 2'b00;
    reg_wr = 1'b0;
    dm_wr  = 1'b0;
    retire = 1'b0;
    case (cur)
      FETCH: begin
        ir_wr = mem_rdy;
        pc_wr = mem_rdy;
        nxt   = mem_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        pc_wr  = j | jal | jr;
        npc_op = jr ? 2'b11 : (j | jal) ? 2'b10 : 2'b00;
        reg_wr = jal;
        retire = j | jal | jr;
        nxt    = (legal && !(j | jal | jr)) ? EXE : FETCH;
      end
      EXE: begin
        npc_op = beq ? 2'b01 : 2'b00;
        pc_wr  = beq & zero;
        retire = beq;
        nxt    = (lw | sw) ? MEM : alu ? WB : FETCH;
      end
      MEM: begin
        dm_wr  = sw;
        retire = sw;
        nxt    = lw ? WB : FETCH;
      end
      WB: begin
        reg_wr = 1'b1;
        retire = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // Enables are masked by reset so nothing is written while the state register is being forced.
  assign PCWr  = rst_n & pc_wr;
  assign IRWr  = rst_n & ir_wr;
  assign RegWr = rst_n & reg_wr;
  assign DMWr  = rst_n & dm_wr;
  assign NPCOp = rst_n ? npc_op : 2'b00;
  assign state = cur;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= FETCH;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: randomized instruction stream checked against a per-instruction cycle table,
// plus directed reset, stall, branch, jump, illegal-opcode and counter-wrap cases.
module tb_pc_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_rdy = 1'b0;
  logic [5:0]  op = '0, funct = '0;
  logic        PCWr, IRWr, RegWr, DMWr;
  logic [1:0]  NPCOp;
  logic [2:0]  state;
  logic [31:0] instr_cnt, exp_cnt = '0;
  int checks = 0, errors = 0;

  pc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .RegWr(RegWr), .DMWr(DMWr),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 illegal, 1 j, 2 jal, 3 jr, 4 beq, 5 addu/subu/ori/lui, 6 sw, 7 lw
  function automatic int kind(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) return f == 6'b001000 ? 3 : (f == 6'b100001 || f == 6'b100011) ? 5 : 0;
    case (o)
      6'b000010: return 1;
      6'b000011: return 2;
      6'b000100: return 4;
      6'b001101, 6'b001111: return 5;
      6'b101011: return 6;
      6'b100011: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int cycles(input int k);
    return k == 7 ? 5 : (k == 5 || k == 6) ? 4 : k == 4 ? 3 : 2;
  endfunction

  // Expected {state, PCWr, IRWr, NPCOp, RegWr, DMWr} in cycle s of an instruction of kind k.
  function automatic logic [8:0] expect_at(input int k, input int s, input logic z);
    if (s == 0) return {3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
    if (s == 1) case (k)
      1: return {3'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
      2: return {3'd1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
      3: return {3'd1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0};
      default: return {3'd1, 6'b0};
    endcase
    if (s == 2) return k == 4 ? {3'd2, z, 1'b0, 2'b01, 2'b00} : {3'd2, 6'b0};
    if (s == 3) return k == 5 ? {3'd4, 4'b0, 1'b1, 1'b0} : k == 6 ? {3'd3, 5'b0, 1'b1} : {3'd3, 6'b0};
    return {3'd4, 4'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [8:0] obs();
    return {state, PCWr, IRWr, NPCOp, RegWr, DMWr};
  endfunction

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
    @(negedge clk);
    op = o; funct = f; zero = z; mem_rdy = r;
    #1;
  endtask

  // zf < 0 randomizes zero every cycle; otherwise zero is held at zf.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int stalls, input int zf, input string tag);
    int k = kind(o, f);
    logic z;
    for (int i = 0; i < stalls; i++) begin
      drive(o, f, 1'($urandom_range(0, 1)), 1'b0);
      check({tag, "_stall"}, 32'(obs()), 32'(9'b0));
    end
    for (int s = 0; s < cycles(k); s++) begin
      z = zf < 0 ? 1'($urandom_range(0, 1)) : 1'(zf);
      drive(o, f, z, 1'b1);
      check($sformatf("%s_c%0d", tag, s), 32'(obs()), 32'(expect_at(k, s, z)));
      check({tag, "_excl"}, 32'({IRWr & DMWr, RegWr & DMWr}), 32'd0);
    end
    if (k != 0) exp_cnt++;
    drive(o, f, 1'b0, 1'b0);
    check({tag, "_end_state"}, 32'(state), 32'd0);
    check({tag, "_cnt"}, instr_cnt, exp_cnt);
  endtask

  initial begin
    logic [5:0] o, f;
    int r;
    op = 6'b100011; mem_rdy = 1'b1;
    #2;
    check("reset_out", 32'(obs()), 32'(9'b0));
    check("reset_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    mem_rdy = 1'b0;
    rst_n = 1'b1;
    run_instr(6'b100011, 6'd0, 3, -1, "lw_stall3");
    run_instr(6'b000100, 6'd0, 0, 0, "beq_z0");
    run_instr(6'b000100, 6'd0, 0, 1, "beq_z1");
    run_instr(6'b000000, 6'b001000, 0, -1, "jr");
    run_instr(6'b111111, 6'd0, 0, -1, "illegal");
    run_instr(6'b000000, 6'b111111, 1, -1, "illegal_funct");
    run_instr(6'b000011, 6'd5, 0, -1, "jal");
    @(negedge clk);
    dut.instr_cnt <= 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    check("preload", instr_cnt, exp_cnt);
    run_instr(6'b000010, 6'd0, 0, -1, "j_wrap");
    check("wrap_zero", instr_cnt, 32'd0);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      f = 6'($urandom);
      case (r)
        0: begin o = 6'b000000; f = 6'b100001; end
        1: begin o = 6'b000000; f = 6'b100011; end
        2: begin o = 6'b000000; f = 6'b001000; end
        3: o = 6'b001101;
        4: o = 6'b001111;
        5: o = 6'b100011;
        6: o = 6'b101011;
        7: o = 6'b000100;
        8: o = 6'b000010;
        9: o = 6'b000011;
        10: o = 6'b111111;
        default: begin o = 6'b000000; f = 6'b000111; end
      endcase
      run_instr(o, f, $urandom_range(0, 2), -1, $sformatf("rnd%0d_op%b", n, o));
    end
    for (int s = 0; s < 4; s++) drive(6'b101011, 6'd0, 1'b0, 1'b1);
    check("sw_mem_state", 32'(state), 32'd3);
    check("sw_mem_dmwr", 32'(DMWr), 32'd1);
    #2 rst_n = 1'b0;
    exp_cnt = '0;
    #1;
    check("midrst_out", 32'(obs()), 32'(9'b0));
    check("midrst_cnt", instr_cnt, exp_cnt);
    @(negedge clk);
    mem_rdy = 1'b0;
    rst_n = 1'b1;
    run_instr(6'b000010, 6'd0, 0, -1, "j_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
